// File: rtl/keypad_pkg.sv
// Shared key codes and controller state encoding for the keypad entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] NO_KEY   = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_SUBMIT = 2'd2
  } state_e;

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational row/column to key-code lookup; ok is low unless both
// row and column are exactly one-hot.
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] code,
  output logic       ok
);

  always_comb begin
    code = NO_KEY;
    ok   = $onehot(row) && $onehot(col);
    case ({row, col})
      8'b0001_0001: code = KEY_1;
      8'b0001_0010: code = KEY_2;
      8'b0001_0100: code = KEY_3;
      8'b0001_1000: code = KEY_A;
      8'b0010_0001: code = KEY_4;
      8'b0010_0010: code = KEY_5;
      8'b0010_0100: code = KEY_6;
      8'b0010_1000: code = KEY_B;
      8'b0100_0001: code = KEY_7;
      8'b0100_0010: code = KEY_8;
      8'b0100_0100: code = KEY_9;
      8'b0100_1000: code = KEY_C;
      8'b1000_0001: code = KEY_STAR;
      8'b1000_0010: code = KEY_0;
      8'b1000_0100: code = KEY_HASH;
      8'b1000_1000: code = KEY_D;
      default:      code = NO_KEY;
    endcase
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: press-edge decode, PIN-style digit buffer with
// '*' clear / '#' submit, inactivity timeout, and a valid/ready code output.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned TIMEOUT_TICKS = 24'd5_000_000,
  parameter int unsigned TIMEOUT_W     = 24,
  localparam int unsigned CW           = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            keypad_col,
  input  logic [3:0]            keypad_row,
  input  logic                  key_pressed,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic [4*DIGITS-1:0]   code_out,
  output logic [CW-1:0]         code_len,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [CW-1:0]         digit_count,
  output logic                  overflow,
  output logic                  entry_timeout,
  output logic                  decode_err,
  output state_e                state_dbg
);

  localparam logic                 TO_EN   = (TIMEOUT_TICKS != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0]        FULL    = CW'(DIGITS);

  state_e                state_q, state_d;
  logic                  kp_q;
  logic [3:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic [4*DIGITS-1:0]   buf_q, buf_d;
  logic [CW-1:0]         count_q, count_d;
  logic [4*DIGITS-1:0]   code_out_q, code_out_d;
  logic [CW-1:0]         code_len_q, code_len_d;
  logic                  code_valid_q, code_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  decode_err_q, decode_err_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;

  logic [3:0]            dec_code;
  logic                  dec_ok;
  logic                  new_press, accept, is_digit;
  logic [4*DIGITS+3:0]   buf_wide;
  logic [4*DIGITS-1:0]   buf_shift;

  keypad_key_decode u_decode (
    .row  (keypad_row),
    .col  (keypad_col),
    .code (dec_code),
    .ok   (dec_ok)
  );

  assign new_press = key_pressed & ~kp_q;
  assign accept    = new_press & dec_ok;
  assign is_digit  = (dec_code <= KEY_9);
  // Widen before truncating so the shift also works for a one-digit buffer.
  assign buf_wide  = {buf_q, dec_code};
  assign buf_shift = buf_wide[4*DIGITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      kp_q         <= 1'b0;
      key_code_q   <= NO_KEY;
      key_valid_q  <= 1'b0;
      buf_q        <= '0;
      count_q      <= '0;
      code_out_q   <= '0;
      code_len_q   <= '0;
      code_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      decode_err_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      kp_q         <= key_pressed;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      code_out_q   <= code_out_d;
      code_len_q   <= code_len_d;
      code_valid_q <= code_valid_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      decode_err_q <= decode_err_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Output handshake: code_out/code_len are stable while code_valid is high;
  // a transfer happens on a clock edge where code_valid && code_ready, and
  // code_valid drops on the following cycle. code_ready alone does nothing.
  always_comb begin
    state_d      = state_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    buf_d        = buf_q;
    count_d      = count_q;
    code_out_d   = code_out_q;
    code_len_d   = code_len_q;
    code_valid_d = code_valid_q;
    overflow_d   = 1'b0;
    timeout_d    = 1'b0;
    decode_err_d = new_press & ~dec_ok;
    to_cnt_d     = '0;

    if (accept) begin
      key_code_d  = dec_code;
      key_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && is_digit) begin
          buf_d   = buf_shift;
          count_d = CW'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // An accepted key outranks a timeout due on the same edge.
        if (accept) begin
          if (is_digit) begin
            if (count_q == FULL) begin
              overflow_d = 1'b1;
            end else begin
              buf_d   = buf_shift;
              count_d = count_q + 1'b1;
            end
          end else if (dec_code == KEY_STAR) begin
            buf_d   = '0;
            count_d = '0;
            state_d = S_IDLE;
          end else if (dec_code == KEY_HASH) begin
            code_out_d   = buf_q;
            code_len_d   = count_q;
            code_valid_d = 1'b1;
            state_d      = S_SUBMIT;
          end
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          buf_d     = '0;
          count_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_SUBMIT: begin
        if (code_valid_q && code_ready) begin
          code_valid_d = 1'b0;
          buf_d        = '0;
          count_d      = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign code_out      = code_out_q;
  assign code_len      = code_len_q;
  assign code_valid    = code_valid_q;
  assign digit_count   = count_q;
  assign overflow      = overflow_q;
  assign entry_timeout = timeout_q;
  assign decode_err    = decode_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a press table plus hand-written
// sequences for handshake, overflow, clear, timeout and async reset.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int DIGITS = 4;
  localparam int CW     = $clog2(DIGITS + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         keypad_col, keypad_row;
  logic               key_pressed;
  logic [3:0]         key_code;
  logic               key_valid;
  logic [4*DIGITS-1:0] code_out;
  logic [CW-1:0]      code_len;
  logic               code_valid;
  logic               code_ready;
  logic [CW-1:0]      digit_count;
  logic               overflow, entry_timeout, decode_err;
  state_e             state_dbg;

  int checks = 0;
  int errors = 0;

  keypad_entry_ctrl #(
    .DIGITS(DIGITS), .TIMEOUT_TICKS(100), .TIMEOUT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keypad_col(keypad_col), .keypad_row(keypad_row),
    .key_pressed(key_pressed), .key_code(key_code), .key_valid(key_valid),
    .code_out(code_out), .code_len(code_len), .code_valid(code_valid),
    .code_ready(code_ready), .digit_count(digit_count), .overflow(overflow),
    .entry_timeout(entry_timeout), .decode_err(decode_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic       exp_kv;
    logic [3:0] exp_code;
    logic       exp_err;
    logic [2:0] exp_cnt;
    state_e     exp_st;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inverse of the keypad map: key code -> {row, col}.
  function automatic logic [7:0] rc(input logic [3:0] k);
    case (k)
      4'h1: return 8'b0001_0001;
      4'h2: return 8'b0001_0010;
      4'h3: return 8'b0001_0100;
      4'hA: return 8'b0001_1000;
      4'h4: return 8'b0010_0001;
      4'h5: return 8'b0010_0010;
      4'h6: return 8'b0010_0100;
      4'hB: return 8'b0010_1000;
      4'h7: return 8'b0100_0001;
      4'h8: return 8'b0100_0010;
      4'h9: return 8'b0100_0100;
      4'hC: return 8'b0100_1000;
      4'hE: return 8'b1000_0001;
      4'h0: return 8'b1000_0010;
      4'hF: return 8'b1000_0100;
      default: return 8'b1000_1000;
    endcase
  endfunction

  task automatic press_raw(input logic [3:0] row, input logic [3:0] col);
    keypad_row  = row;
    keypad_col  = col;
    key_pressed = 1'b1;
    tick();
  endtask

  task automatic press_key(input logic [3:0] k);
    logic [7:0] p;
    p = rc(k);
    press_raw(p[7:4], p[3:0]);
  endtask

  task automatic release_key();
    key_pressed = 1'b0;
    tick();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; keypad_row = '0; keypad_col = '0; key_pressed = 1'b0; code_ready = 1'b0;
    tick(); tick();
    check("rst key_valid", 32'(key_valid), 0);
    check("rst code_valid", 32'(code_valid), 0);
    check("rst code_out", 32'(code_out), 0);
    check("rst digit_count", 32'(digit_count), 0);
    check("rst state", 32'(state_dbg), 32'(S_IDLE));
    rst_n = 1'b1;
    tick();

    // Table: code_ready held low so the final '#' leaves a code pending.
    vecs[0]  = '{4'b0001, 4'b1000, 1'b1, KEY_A,    1'b0, 3'd0, S_IDLE};
    vecs[1]  = '{4'b1000, 4'b0001, 1'b1, KEY_STAR, 1'b0, 3'd0, S_IDLE};
    vecs[2]  = '{4'b1000, 4'b0100, 1'b1, KEY_HASH, 1'b0, 3'd0, S_IDLE};
    vecs[3]  = '{4'b0011, 4'b0001, 1'b0, KEY_HASH, 1'b1, 3'd0, S_IDLE};
    vecs[4]  = '{4'b0001, 4'b0001, 1'b1, KEY_1,    1'b0, 3'd1, S_ENTRY};
    vecs[5]  = '{4'b0001, 4'b0010, 1'b1, KEY_2,    1'b0, 3'd2, S_ENTRY};
    vecs[6]  = '{4'b0001, 4'b0100, 1'b1, KEY_3,    1'b0, 3'd3, S_ENTRY};
    vecs[7]  = '{4'b0010, 4'b0001, 1'b1, KEY_4,    1'b0, 3'd4, S_ENTRY};
    vecs[8]  = '{4'b0100, 4'b0000, 1'b0, KEY_4,    1'b1, 3'd4, S_ENTRY};
    vecs[9]  = '{4'b0010, 4'b1000, 1'b1, KEY_B,    1'b0, 3'd4, S_ENTRY};
    vecs[10] = '{4'b1000, 4'b0100, 1'b1, KEY_HASH, 1'b0, 3'd4, S_SUBMIT};

    for (int i = 0; i < 11; i++) begin
      press_raw(vecs[i].row, vecs[i].col);
      check($sformatf("v%0d key_valid", i), 32'(key_valid), 32'(vecs[i].exp_kv));
      check($sformatf("v%0d key_code", i), 32'(key_code), 32'(vecs[i].exp_code));
      check($sformatf("v%0d decode_err", i), 32'(decode_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d digit_count", i), 32'(digit_count), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d state", i), 32'(state_dbg), 32'(vecs[i].exp_st));
      release_key();
      check($sformatf("v%0d key_valid pulse", i), 32'(key_valid), 0);
      check($sformatf("v%0d decode_err pulse", i), 32'(decode_err), 0);
    end
    check("submit code_valid", 32'(code_valid), 1);
    check("submit code_out", 32'(code_out), 32'h1234);
    check("submit code_len", 32'(code_len), 4);

    // Pending code, key press has no buffer effect.
    press_key(KEY_9);
    check("pend key_valid", 32'(key_valid), 1);
    check("pend key_code", 32'(key_code), 9);
    check("pend code_out", 32'(code_out), 32'h1234);
    check("pend code_valid", 32'(code_valid), 1);
    check("pend digit_count", 32'(digit_count), 4);
    key_pressed = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async key_valid", 32'(key_valid), 0);
    check("async key_code", 32'(key_code), 0);
    check("async code_valid", 32'(code_valid), 0);
    check("async code_out", 32'(code_out), 0);
    check("async code_len", 32'(code_len), 0);
    check("async digit_count", 32'(digit_count), 0);
    check("async state", 32'(state_dbg), 32'(S_IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // Submit with code_ready held high.
    code_ready = 1'b1;
    foreach (vecs[i]) if (i >= 4 && i <= 7) begin press_key(KEY_1 + 4'(i - 4)); release_key(); end
    press_key(KEY_HASH);
    check("hs code_valid", 32'(code_valid), 1);
    check("hs code_out", 32'(code_out), 32'h1234);
    release_key();
    check("hs code_valid drop", 32'(code_valid), 0);
    check("hs digit_count", 32'(digit_count), 0);
    check("hs state", 32'(state_dbg), 32'(S_IDLE));
    check("hs code_out hold", 32'(code_out), 32'h1234);

    // Overflow on the fifth digit.
    for (int d = 5; d <= 8; d++) begin press_key(4'(d)); release_key(); end
    press_key(KEY_9);
    check("ovf pulse", 32'(overflow), 1);
    check("ovf digit_count", 32'(digit_count), 4);
    release_key();
    check("ovf pulse end", 32'(overflow), 0);
    press_key(KEY_HASH);
    check("ovf code_out", 32'(code_out), 32'h5678);
    check("ovf code_len", 32'(code_len), 4);
    release_key();

    // Clear then empty submit.
    press_key(KEY_7); release_key();
    press_key(KEY_8); release_key();
    press_key(KEY_STAR);
    check("clr digit_count", 32'(digit_count), 0);
    check("clr state", 32'(state_dbg), 32'(S_IDLE));
    release_key();
    press_key(KEY_HASH);
    check("clr hash key_valid", 32'(key_valid), 1);
    check("clr code_valid", 32'(code_valid), 0);
    check("clr hash state", 32'(state_dbg), 32'(S_IDLE));
    release_key();

    // Timeout fires 100 cycles after key_valid.
    press_key(KEY_3);
    key_pressed = 1'b0;
    seen = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (entry_timeout) begin seen = k; break; end
    end
    check("to cycle", 32'(seen), 100);
    check("to digit_count", 32'(digit_count), 0);
    check("to state", 32'(state_dbg), 32'(S_IDLE));
    tick();
    check("to pulse end", 32'(entry_timeout), 0);

    // Key lands on the edge where the timeout would fire.
    press_key(KEY_3);
    key_pressed = 1'b0;
    seen = 0;
    for (int k = 1; k <= 99; k++) begin
      tick();
      if (entry_timeout) seen++;
    end
    check("race early timeout", 32'(seen), 0);
    press_key(KEY_5);
    check("race entry_timeout", 32'(entry_timeout), 0);
    check("race key_valid", 32'(key_valid), 1);
    check("race digit_count", 32'(digit_count), 2);
    check("race state", 32'(state_dbg), 32'(S_ENTRY));
    release_key();
    press_key(KEY_STAR);
    release_key();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
